// File: rtl/tia_sr_bank.sv
// tia_sr_bank: bank of clocked set/reset flags with conflict modes,
// global clear, indexed readback, first-event capture and event counter.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   set, rst              per-channel OR'd set/reset sources
//   clear_all             clears channels, first-event and counter
//   read_en, read_sel     registered single-bit readback request
//   q, q_bar, rise        flag state, its inverse, 0->1 pulse
//   read_data, read_valid readback result, one cycle after request
//   first_valid/first_idx lowest channel of the first rising cycle
//   event_count           saturating count of cycles with any rise
module tia_sr_bank #(
   parameter  int CHANNELS      = 15,
   parameter  int SET_SRC       = 2,
   parameter  int RST_SRC       = 2,
   parameter  int CONFLICT_MODE = 0,
   parameter  int CLEAR_ON_READ = 0,
   parameter  int CNT_WIDTH     = 8,
   localparam int SEL_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [CHANNELS*SET_SRC-1:0] set,
   input  logic [CHANNELS*RST_SRC-1:0] rst,
   input  logic                        clear_all,
   input  logic                        read_en,
   input  logic [SEL_W-1:0]            read_sel,
   output logic [CHANNELS-1:0]         q,
   output logic [CHANNELS-1:0]         q_bar,
   output logic [CHANNELS-1:0]         rise,
   output logic                        read_data,
   output logic                        read_valid,
   output logic                        first_valid,
   output logic [SEL_W-1:0]            first_idx,
   output logic [CNT_WIDTH-1:0]        event_count
);

   localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

   logic [CHANNELS-1:0] s_any;
   logic [CHANNELS-1:0] r_any;
   logic [CHANNELS-1:0] base;
   logic [CHANNELS-1:0] q_next;
   logic [CHANNELS-1:0] rise_next;
   logic                rd_hit;
   logic                rd_bit;
   logic                any_rise;
   logic [SEL_W-1:0]    lo_idx;

   // Conflict resolution against the (possibly cleared) base value.
   function automatic logic resolve(input logic b);
      logic v;
      v = b;
      unique case (CONFLICT_MODE)
         1:       v = 1'b1;
         2:       v = 1'b0;
         3:       v = ~b;
         default: v = b;
      endcase
      return v;
   endfunction

   always_comb begin
      s_any     = '0;
      r_any     = '0;
      base      = '0;
      q_next    = '0;
      rise_next = '0;
      lo_idx    = '0;
      rd_hit    = read_en && ({1'b0, read_sel} < CH_LIM);
      rd_bit    = rd_hit ? q[read_sel] : 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         s_any[c] = |set[c*SET_SRC +: SET_SRC];
         r_any[c] = |rst[c*RST_SRC +: RST_SRC];
         // Clears only zero the base; the S/R evaluation still applies.
         base[c]  = q[c] & ~clear_all;
         if ((CLEAR_ON_READ != 0) && rd_hit && (read_sel == SEL_W'(c)))
            base[c] = 1'b0;
         unique case ({s_any[c], r_any[c]})
            2'b10:   q_next[c] = 1'b1;
            2'b01:   q_next[c] = 1'b0;
            2'b11:   q_next[c] = resolve(base[c]);
            default: q_next[c] = base[c];
         endcase
         rise_next[c] = q_next[c] & ~q[c];
      end
      // Scan downward so the lowest rising index is the one kept.
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (rise_next[c])
            lo_idx = SEL_W'(c);
      end
      any_rise = |rise_next;
   end

   assign q_bar = ~q;

   always_ff @(posedge clock) begin
      if (reset) begin
         q           <= '0;
         rise        <= '0;
         read_data   <= 1'b0;
         read_valid  <= 1'b0;
         first_valid <= 1'b0;
         first_idx   <= '0;
         event_count <= '0;
      end else begin
         q          <= q_next;
         rise       <= rise_next;
         read_valid <= read_en;
         if (read_en)
            read_data <= rd_bit;
         if (clear_all) begin
            first_valid <= any_rise;
            first_idx   <= any_rise ? lo_idx : '0;
            event_count <= CNT_WIDTH'(any_rise);
         end else begin
            if (!first_valid && any_rise) begin
               first_valid <= 1'b1;
               first_idx   <= lo_idx;
            end
            if (any_rise && !(&event_count))
               event_count <= event_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tia_sr_bank.sv
// tb_tia_sr_bank: directed checks of tia_sr_bank in four conflict modes,
// clear-on-read enabled; instance 3 also uses a 2-bit event counter.
module tb_tia_sr_bank;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [29:0] set   = '0;
   logic [29:0] rst   = '0;
   logic        clear_all = 1'b0;
   logic        read_en   = 1'b0;
   logic [3:0]  read_sel  = '0;

   logic [14:0] q     [4];
   logic [14:0] q_bar [4];
   logic [14:0] rise  [4];
   logic        rdat  [4];
   logic        rval  [4];
   logic        fval  [4];
   logic [3:0]  fidx  [4];
   logic [7:0]  cnt   [4];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int CW = (g == 3) ? 2 : 8;
      logic [CW-1:0] cw;
      assign cnt[g] = 8'(cw);
      tia_sr_bank #(
         .CHANNELS(15), .SET_SRC(2), .RST_SRC(2),
         .CONFLICT_MODE(g), .CLEAR_ON_READ(1), .CNT_WIDTH(CW)
      ) u_dut (
         .clock(clock), .reset(reset), .set(set), .rst(rst),
         .clear_all(clear_all), .read_en(read_en), .read_sel(read_sel),
         .q(q[g]), .q_bar(q_bar[g]), .rise(rise[g]),
         .read_data(rdat[g]), .read_valid(rval[g]),
         .first_valid(fval[g]), .first_idx(fidx[g]),
         .event_count(cw)
      );
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   initial begin
      step();
      step();
      reset = 1'b0;
      chk("rst_q",     32'(q[0]), 32'h0000);
      chk("rst_qbar",  32'(q_bar[0]), 32'h7FFF);
      chk("rst_cnt",   32'(cnt[0]), 0);
      chk("rst_fval",  32'(fval[0]), 0);

      // set ch3 via source 1
      set[7] = 1'b1;
      step();
      chk("s3_q",      32'(q[0]), 32'h0008);
      chk("s3_rise",   32'(rise[0]), 32'h0008);
      set = '0;
      step();
      chk("s3_rise0",  32'(rise[0]), 32'h0000);
      chk("s3_hold",   32'(q[0]), 32'h0008);
      chk("s3_cnt",    32'(cnt[0]), 1);
      chk("s3_fval",   32'(fval[0]), 1);
      chk("s3_fidx",   32'(fidx[0]), 3);
      rst[6] = 1'b1;
      step();
      rst = '0;
      chk("r3_q",      32'(q[0]), 32'h0000);
      chk("r3_rise",   32'(rise[0]), 32'h0000);

      // fill all channels, count up to 5, then reset mid-run
      for (int c = 0; c < 15; c++) set[c*2] = 1'b1;
      step();
      set = '0;
      for (int i = 0; i < 3; i++) begin
         rst[0] = 1'b1;
         step();
         rst[0] = 1'b0;
         set[0] = 1'b1;
         step();
         set[0] = 1'b0;
      end
      chk("fill_q",    32'(q[0]), 32'h7FFF);
      chk("fill_cnt",  32'(cnt[0]), 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_q",      32'(q[0]), 32'h0000);
      chk("mr_qbar",   32'(q_bar[0]), 32'h7FFF);
      chk("mr_rise",   32'(rise[0]), 32'h0000);
      chk("mr_rdat",   32'(rdat[0]), 0);
      chk("mr_rval",   32'(rval[0]), 0);
      chk("mr_fval",   32'(fval[0]), 0);
      chk("mr_fidx",   32'(fidx[0]), 0);
      chk("mr_cnt",    32'(cnt[0]), 0);

      // S&R conflict on ch0, two cycles
      set[0] = 1'b1;
      rst[0] = 1'b1;
      step();
      chk("cf1_m0",    32'(q[0][0]), 0);
      chk("cf1_m1",    32'(q[1][0]), 1);
      chk("cf1_m2",    32'(q[2][0]), 0);
      chk("cf1_m3",    32'(q[3][0]), 1);
      step();
      chk("cf2_m0",    32'(q[0][0]), 0);
      chk("cf2_m1",    32'(q[1][0]), 1);
      chk("cf2_m2",    32'(q[2][0]), 0);
      chk("cf2_m3",    32'(q[3][0]), 0);
      set = '0;
      rst = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;

      // clear_all with same-cycle set of an already-set channel
      set[0]  = 1'b1;
      set[14] = 1'b1;
      step();
      set = '0;
      chk("ca_pre",    32'(q[0]), 32'h0081);
      clear_all = 1'b1;
      set[14]   = 1'b1;
      step();
      clear_all = 1'b0;
      set = '0;
      chk("ca_q",      32'(q[0]), 32'h0080);
      chk("ca_rise",   32'(rise[0]), 32'h0000);
      chk("ca_fval",   32'(fval[0]), 0);
      chk("ca_cnt",    32'(cnt[0]), 0);

      // clear-on-read
      set[4] = 1'b1;
      step();
      set = '0;
      chk("cr_pre",    32'(q[0]), 32'h0084);
      read_en  = 1'b1;
      read_sel = 4'd2;
      step();
      read_en = 1'b0;
      chk("cr_rdat",   32'(rdat[0]), 1);
      chk("cr_rval",   32'(rval[0]), 1);
      chk("cr_q",      32'(q[0]), 32'h0080);
      step();
      chk("cr_rval0",  32'(rval[0]), 0);
      set[4] = 1'b1;
      step();
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      set = '0;
      chk("crs_rdat",  32'(rdat[0]), 1);
      chk("crs_q",     32'(q[0]), 32'h0084);
      chk("crs_rise",  32'(rise[0]), 32'h0000);
      read_en  = 1'b1;
      read_sel = 4'd15;
      step();
      read_en = 1'b0;
      chk("oor_rdat",  32'(rdat[0]), 0);
      chk("oor_rval",  32'(rval[0]), 1);
      chk("oor_q",     32'(q[0]), 32'h0084);
      read_en   = 1'b1;
      read_sel  = 4'd7;
      clear_all = 1'b1;
      step();
      read_en   = 1'b0;
      clear_all = 1'b0;
      chk("rc_rdat",   32'(rdat[0]), 1);
      chk("rc_rval",   32'(rval[0]), 1);
      chk("rc_q",      32'(q[0]), 32'h0000);

      // counter: multi-channel rise counts once, 2-bit saturates
      reset = 1'b1;
      step();
      reset = 1'b0;
      set[18] = 1'b1;
      set[8]  = 1'b1;
      step();
      set = '0;
      chk("mc_cnt",    32'(cnt[0]), 1);
      chk("mc_fidx",   32'(fidx[0]), 4);
      chk("mc_c2",     32'(cnt[3]), 1);
      for (int c = 0; c < 4; c++) begin
         set = '0;
         set[c*2] = 1'b1;
         step();
         chk("sat_c2",  32'(cnt[3]), (c == 0) ? 2 : 3);
      end
      set = '0;
      chk("sat_c8",    32'(cnt[0]), 5);
      chk("sat_fidx",  32'(fidx[0]), 4);
      chk("sat_q",     32'(q[0]), 32'h021F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
